// File: rtl/pipe_scheduler_if.sv
// Control/status bundle for the pipe scheduler: stimulus in, slot table and score out.
interface pipe_scheduler_if #(parameter int N_PIPE = 3);
  logic [7:0]          n_row;
  logic                start;
  logic                halt;
  logic [24*N_PIPE-1:0] pipes;
  logic [15:0]         score;
  logic                pass_pulse;
  logic                running;

  modport master (output n_row, start, halt, input pipes, score, pass_pulse, running);
  modport slave  (input n_row, start, halt, output pipes, score, pass_pulse, running);
endinterface

// File: rtl/pipe_scheduler.sv
// Scrolling pipe-slot scheduler: fills slots with LFSR-drawn gaps, scrolls them past
// the bird column, recycles the front slot to the back and counts passes.
module pipe_scheduler #(
  parameter int          N_PIPE   = 3,
  parameter int          STEP_DIV = 3,
  parameter int          PIPE_GAP = 50,
  parameter int          GAP_LEN  = 8,
  parameter int          BIRD_COL = 10,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic             clk,
  input logic             rst_n,
  pipe_scheduler_if.slave bus
);
  localparam int          KW       = (N_PIPE > 1) ? $clog2(N_PIPE) : 1;
  localparam int          DW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [7:0]  GAP8     = 8'(GAP_LEN);
  localparam logic [7:0]  PGAP8    = 8'(PIPE_GAP);
  localparam logic [7:0]  BIRD8    = 8'(BIRD_COL);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, FILL, RUN, STOPPED} state_t;

  state_t                       r_state;
  logic [KW-1:0]                r_k;
  logic [DW-1:0]                r_div;
  logic [15:0]                  r_score;
  logic                         r_pass;
  logic                         r_running;
  logic [15:0]                  r_lfsr;
  logic [N_PIPE-1:0][7:0]       r_pos, r_max, r_min;

  logic        w_start, w_fill, w_step, w_recyc, w_dec, w_pass, w_range;
  logic [7:0]  w_divisor, w_min;
  logic [15:0] w_mod, w_lfsr_nxt;

  assign w_start = ((r_state == IDLE) || (r_state == STOPPED)) && bus.start;
  assign w_fill  = (r_state == FILL) && !bus.halt;
  assign w_step  = (r_state == RUN) && !bus.halt && (r_div == DW'(STEP_DIV - 1));
  assign w_recyc = w_step && (r_pos[0] == 8'd0);
  assign w_dec   = w_step && (r_pos[0] != 8'd0);
  assign w_pass  = w_step && (r_pos[0] == BIRD8);

  // Divisor forced to 1 when the screen is too short so the modulo never sees zero.
  assign w_range    = bus.n_row > GAP8;
  assign w_divisor  = w_range ? (bus.n_row - GAP8) : 8'd1;
  assign w_mod      = r_lfsr % {8'd0, w_divisor};
  assign w_min      = w_range ? w_mod[7:0] : 8'd0;
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_div     <= '0;
      r_score   <= '0;
      r_pass    <= 1'b0;
      r_running <= 1'b0;
      r_lfsr    <= SEED_EFF;
    end else begin
      r_pass <= w_pass;
      case (r_state)
        IDLE, STOPPED: if (bus.start) begin
          r_state <= FILL;
          r_k     <= '0;
          r_div   <= '0;
          r_score <= '0;
        end
        FILL: if (bus.halt) begin
          r_state <= STOPPED;
        end else begin
          r_lfsr <= w_lfsr_nxt;
          if (r_k == KW'(N_PIPE - 1)) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        RUN: if (bus.halt) begin
          r_state   <= STOPPED;
          r_running <= 1'b0;
        end else begin
          r_div <= w_step ? '0 : r_div + 1'b1;
          if (w_recyc) r_lfsr <= w_lfsr_nxt;
          if (w_pass && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_PIPE; i++) begin : g_slot
    localparam logic [7:0] INIT = 8'(50 * (i + 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pos[i] <= INIT;
        r_min[i] <= 8'd0;
        r_max[i] <= GAP8;
      end else if (w_start) begin
        r_pos[i] <= INIT;
      end else if (w_fill && r_k == KW'(i)) begin
        r_min[i] <= w_min;
        r_max[i] <= w_min + GAP8;
      end else if (w_recyc) begin
        if (i == N_PIPE - 1) begin
          r_pos[i] <= r_pos[N_PIPE-1] + PGAP8;
          r_min[i] <= w_min;
          r_max[i] <= w_min + GAP8;
        end else begin
          r_pos[i] <= r_pos[(i+1) % N_PIPE];
          r_min[i] <= r_min[(i+1) % N_PIPE];
          r_max[i] <= r_max[(i+1) % N_PIPE];
        end
      end else if (w_dec) begin
        r_pos[i] <= r_pos[i] - 8'd1;
      end
    end
    assign bus.pipes[24*i +: 24] = {r_pos[i], r_max[i], r_min[i]};
  end

  assign bus.score      = r_score;
  assign bus.pass_pulse = r_pass;
  assign bus.running    = r_running;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench: stimulus queues expected snapshots and pass events; a negedge
// monitor pops and compares them independently of the stimulus thread.
module tb_pipe_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  pipe_scheduler_if #(.N_PIPE(3)) bus ();
  pipe_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          at;
    logic [71:0] pipes;
    logic [15:0] score;
    logic        running;
    logic        pass;
  } exp_t;

  exp_t        q[$];
  logic [15:0] pq[$];
  exp_t        e;

  function automatic logic [71:0] mk(input logic [7:0] p0, x0, n0, p1, x1, n1, p2, x2, n2);
    return {p2, x2, n2, p1, x1, n1, p0, x0, n0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input string nm, input logic [71:0] p, input logic [15:0] s,
                             input logic r, input logic pp);
    exp_t x;
    x.name = nm; x.at = cyc; x.pipes = p; x.score = s; x.running = r; x.pass = pp;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (bus.pipes !== e.pipes || bus.score !== e.score || bus.running !== e.running ||
          bus.pass_pulse !== e.pass) begin
        miscompares++;
        $display("FAIL %s: got pipes=%h score=%0d run=%b pass=%b, want pipes=%h score=%0d run=%b pass=%b",
                 e.name, bus.pipes, bus.score, bus.running, bus.pass_pulse,
                 e.pipes, e.score, e.running, e.pass);
      end
    end
    if (bus.pass_pulse === 1'b1) begin
      vectors++;
      if (pq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pass: got pass_pulse=1 score=%0d, want no pass", bus.score);
      end else begin
        logic [15:0] s;
        s = pq.pop_front();
        if (bus.score !== s) begin
          miscompares++;
          $display("FAIL pass_score: got %0d, want %0d", bus.score, s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [71:0] RST, REC, P9;
    RST = mk(50, 8, 0, 100, 8, 0, 150, 8, 0);
    REC = mk(50, 8, 0, 100, 16, 8, 150, 20, 12);
    P9  = mk(9, 9, 1, 59, 8, 0, 109, 16, 8);

    rst_n = 1'b0; bus.n_row = 8'd24; bus.start = 1'b0; bus.halt = 1'b0;
    tick(2);
    expect_snap("reset", RST, 16'd0, 1'b0, 1'b0);

    rst_n = 1'b1; bus.start = 1'b1; tick(1); bus.start = 1'b0;
    tick(3);
    expect_snap("fill", mk(50, 9, 1, 100, 8, 0, 150, 16, 8), 16'd0, 1'b1, 1'b0);

    tick(120);
    expect_snap("step40", mk(10, 9, 1, 60, 8, 0, 110, 16, 8), 16'd0, 1'b1, 1'b0);
    pq.push_back(16'd1);
    tick(3);
    expect_snap("pass", P9, 16'd1, 1'b1, 1'b1);
    tick(1);
    expect_snap("pass_end", P9, 16'd1, 1'b1, 1'b0);

    tick(26);
    expect_snap("scroll150", mk(0, 9, 1, 50, 8, 0, 100, 16, 8), 16'd1, 1'b1, 1'b0);
    tick(3);
    expect_snap("recycle", REC, 16'd1, 1'b1, 1'b0);

    tick(2); bus.halt = 1'b1; tick(1); bus.halt = 1'b0;
    expect_snap("halt", REC, 16'd1, 1'b0, 1'b0);
    tick(5);
    expect_snap("hold", REC, 16'd1, 1'b0, 1'b0);

    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    expect_snap("restart", REC, 16'd0, 1'b0, 1'b0);
    tick(3);
    expect_snap("refill", mk(50, 22, 14, 100, 15, 7, 150, 11, 3), 16'd0, 1'b1, 1'b0);

    bus.halt = 1'b1; tick(1); bus.halt = 1'b0;
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    tick(1);
    rst_n = 1'b0;
    expect_snap("async_rst", RST, 16'd0, 1'b0, 1'b0);
    bus.n_row = 8'd8;
    tick(1);
    expect_snap("rst_held", RST, 16'd0, 1'b0, 1'b0);

    rst_n = 1'b1; bus.start = 1'b1; tick(1); bus.start = 1'b0;
    tick(3);
    expect_snap("fill_narrow", RST, 16'd0, 1'b1, 1'b0);
    tick(3);
    expect_snap("step_narrow", mk(49, 8, 0, 99, 8, 0, 149, 8, 0), 16'd0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0 || pq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d snapshots and %0d passes left, want 0", q.size(), pq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 The block SHALL have parameter N_PIPE, default 3: number of pipe slots.
REQ-002 The block SHALL have parameter STEP_DIV, default 3: clock cycles per scroll step.
REQ-003 The block SHALL have parameter PIPE_GAP, default 50: column spacing used when a slot is recycled.
REQ-004 The block SHALL have parameter GAP_LEN, default 8: vertical gap height (max - min).
REQ-005 The block SHALL have parameter BIRD_COL, default 10: column the bird occupies.
REQ-006 The block SHALL have parameter SEED, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, all state on posedge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port n_row, input, 8 bits: screen rows, held stable outside reset.
REQ-010 The block SHALL have port start, input, 1 bit: level, sampled each cycle.
REQ-011 The block SHALL have port halt, input, 1 bit: level, sampled each cycle.
REQ-012 The block SHALL have port pipes, output, 24*N_PIPE bits: slot i at [24*i+:24] = {pos[7:0], max[7:0], min[7:0]}; slot 0 is frontmost.
REQ-013 The block SHALL have port score, output, 16 bits: pipes passed, saturating.
REQ-014 The block SHALL have port pass_pulse, output, 1 bit: one-cycle pulse per pipe passed.
REQ-015 The block SHALL have port running, output, 1 bit: high exactly in state RUN.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, RUN and STOPPED, with transitions evaluated on posedge clk.
REQ-017 In IDLE, start=1 SHALL load pos[i] = 50*(i+1), clear div and score, clear fill index k, and go to FILL.
REQ-018 FILL SHALL take N_PIPE cycles; each cycle writes slot k min = draw (REQ-023), writes max = min + GAP_LEN, and advances the LFSR; after slot N_PIPE-1 the FSM SHALL go to RUN.
REQ-019 In RUN, div SHALL count 0..STEP_DIV-1 and wrap; a step SHALL occur in the cycle with div == STEP_DIV-1.
REQ-020 On a step with pos[0] != 0, every pos SHALL decrement by 1, and min/max SHALL be unchanged.
REQ-021 On a step with pos[0] == 0 (recycle), the block SHALL:
- shift slots down (slot i <= slot i+1);
- set the new last slot's pos = old last pos + PIPE_GAP (8-bit wrap) and min = draw;
- advance the LFSR;
- leave other positions undecremented that step.
REQ-022 On a step with pos[0] == BIRD_COL, pass_pulse SHALL be 1 in the following cycle and score SHALL increment, holding at 16'hFFFF.
REQ-023 draw SHALL be the current LFSR value mod (n_row - GAP_LEN) when n_row > GAP_LEN, else 0; min SHALL be the low 8 bits.
REQ-024 The LFSR SHALL be 16-bit Galois, right shift, with next = (l>>1) ^ (l[0] ? 16'hB400 : 0), advancing only on a draw.
REQ-025 In FILL or RUN, halt=1 SHALL go to STOPPED with no step, draw or score change that cycle; halt has priority over a step.
REQ-026 In STOPPED, all slots, score and LFSR SHALL hold; start=1 SHALL act as REQ-017 (reload, FILL); the LFSR SHALL not be reseeded.
REQ-027 start SHALL be ignored in FILL/RUN; halt SHALL be ignored in IDLE/STOPPED; start and halt both high in IDLE SHALL mean start wins.
REQ-028 pipes, score and running SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-029 While rst_n=0, regardless of state (including mid-FILL and mid-step), the block SHALL force:
- state IDLE;
- pos = {150,100,50} (slot2..slot0), min = 0, max = GAP_LEN;
- div 0, score 0, pass_pulse 0, running 0;
- LFSR = SEED.
REQ-030 The first start SHALL be sampled on the first posedge after rst_n rises.

Verification
REQ-031 Bench SHALL check fill: default params, n_row=24, start for 1 cycle -> after 3 cycles mins (slot0..2) = 1, 0, 8, maxs = 9, 8, 16, and running=1.
REQ-032 Bench SHALL check scroll: RUN 150 cycles -> pos = 0, 50, 100; the next step recycles -> slot0 = {50,8,0}, slot1 = {100,16,8}, slot2 pos = 150.
REQ-033 Bench SHALL check pass: the 41st step (pos0 10 -> 9) -> pass_pulse for exactly one cycle, score 0 -> 1.
REQ-034 Bench SHALL check halt: halt in the same cycle as a step -> pos unchanged, state STOPPED, running=0; further cycles -> all outputs hold.
REQ-035 Bench SHALL check restart: start in STOPPED -> score 0, positions 50, 100, 150, and new mins drawn from the continued LFSR sequence (not SEED).
REQ-036 Bench SHALL check async reset: rst_n low mid-FILL between clock edges -> outputs reach reset values immediately; n_row=8 then start -> all mins 0.
